mem_ctrl: RTL and testbench

//  Memory/IO controller between the cpu bus control outputs (mem_ld_mar, mem_ld_mdr, mem_gate_mdr, mem_mio_en, mem_rw)
//  and a synchronous SRAM port plus the LC-3 device registers. Owns MAR/MDR, decodes xFE00-xFFFF, stretches

---
 rtl/mem_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mem_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: LC-3 memory/IO controller. Owns MAR/MDR, drives the SRAM port,
// decodes the device page xFE00-xFFFF and stretches every access by
// WAIT_STATES busy cycles before signalling rdy for one cycle.
module mem_ctrl #(
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned ADDR_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire  [15:0]       bus,
    input  logic              ld_mar,
    input  logic              ld_mdr,
    input  logic              gate_mdr,
    input  logic              mio_en,
    input  logic              rw,
    output logic              rdy,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_wdata,
    input  logic [15:0]       ram_rdata,
    input  logic              kb_valid,
    input  logic [7:0]        kb_data,
    output logic              kb_ready,
    output logic              dsp_valid,
    output logic [7:0]        dsp_data,
    input  logic              dsp_ready,
    output logic              kb_irq,
    output logic              halt
);

    localparam logic [15:0] KBSR_A = 16'hFE00;
    localparam logic [15:0] KBDR_A = 16'hFE02;
    localparam logic [15:0] DSR_A  = 16'hFE04;
    localparam logic [15:0] DDR_A  = 16'hFE06;
    localparam logic [15:0] MCR_A  = 16'hFFFE;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE,
        S_RELEASE
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [15:0] mar;
    logic [15:0] mdr;
    logic [15:0] dev_rbuf;
    logic        kbsr_rdy;
    logic        kbsr_ie;
    logic [7:0]  kbdr;
    logic        dsr_rdy;
    logic [15:0] mcr;
    logic        is_dev;
    logic        last_busy;
    logic [15:0] dev_rdata;

    assign is_dev    = (mar >= 16'hFE00);
    assign last_busy = (state == S_BUSY) && (cnt == 4'd0);

    assign bus       = gate_mdr ? mdr : {16{1'bz}};
    assign ram_en    = (state == S_BUSY) && !is_dev;
    assign ram_we    = last_busy && rw && !is_dev && !rst;
    assign ram_addr  = mar[ADDR_W-1:0];
    assign ram_wdata = mdr;
    assign kb_ready  = ~kbsr_rdy;
    assign kb_irq    = kbsr_rdy & kbsr_ie;
    assign halt      = ~mcr[15];

    // Device register read mux; unmapped device addresses read as zero
    always_comb begin
        dev_rdata = '0;
        case (mar)
            KBSR_A:  dev_rdata = {kbsr_rdy, kbsr_ie, 14'h0};
            KBDR_A:  dev_rdata = {8'h00, kbdr};
            DSR_A:   dev_rdata = {dsr_rdy, 15'h0};
            MCR_A:   dev_rdata = mcr;
            default: dev_rdata = '0;
        endcase
    end

    // Access FSM, MAR/MDR and device registers. Later assignments in this
    // block take priority: a KBDR read-clear beats a keyboard accept, and a
    // DDR write beats a display handshake on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            mar       <= '0;
            mdr       <= '0;
            dev_rbuf  <= '0;
            rdy       <= 1'b0;
            kbsr_rdy  <= 1'b0;
            kbsr_ie   <= 1'b0;
            kbdr      <= '0;
            dsr_rdy   <= 1'b1;
            dsp_valid <= 1'b0;
            dsp_data  <= '0;
            mcr       <= 16'h8000;
        end else begin
            rdy <= 1'b0;

            if (ld_mar && (state != S_BUSY))
                mar <= bus;

            // SRAM output register still holds the word addressed in the
            // last BUSY cycle, so RAM data is taken straight from ram_rdata.
            if (ld_mdr && !mio_en)
                mdr <= bus;
            else if (ld_mdr && rdy)
                mdr <= is_dev ? dev_rbuf : ram_rdata;

            if (kb_valid && !kbsr_rdy) begin
                kbdr     <= kb_data;
                kbsr_rdy <= 1'b1;
            end

            if (dsp_valid && dsp_ready) begin
                dsp_valid <= 1'b0;
                dsr_rdy   <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (mio_en) begin
                        state <= S_BUSY;
                        cnt   <= 4'(WAIT_STATES);
                    end
                end
                S_BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= S_DONE;
                        rdy   <= 1'b1;
                        if (is_dev) begin
                            if (rw) begin
                                case (mar)
                                    KBSR_A: kbsr_ie <= mdr[14];
                                    DDR_A: begin
                                        dsp_data  <= mdr[7:0];
                                        dsp_valid <= 1'b1;
                                        dsr_rdy   <= 1'b0;
                                    end
                                    MCR_A:  mcr <= mdr;
                                    default: ;
                                endcase
                            end else begin
                                dev_rbuf <= dev_rdata;
                                if (mar == KBDR_A)
                                    kbsr_rdy <= 1'b0;
                            end
                        end
                    end
                end
                S_DONE: begin
                    state <= S_RELEASE;
                end
                S_RELEASE: begin
                    if (!mio_en)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: table-driven access vectors with a read-data scoreboard,
// plus hand-written keyboard, display, reset and held-mio_en sequences.
module tb_mem_ctrl;

    localparam int unsigned WS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    wire  [15:0] bus;
    logic        tb_drv = 1'b0;
    logic [15:0] tb_bus = '0;
    logic        ld_mar = 1'b0, ld_mdr = 1'b0, gate_mdr = 1'b0, mio_en = 1'b0, rw = 1'b0;
    logic        rdy, ram_en, ram_we;
    logic [15:0] ram_addr, ram_wdata;
    logic [15:0] ram_rdata = '0;
    logic        kb_valid = 1'b0;
    logic [7:0]  kb_data = '0;
    logic        kb_ready, dsp_valid, kb_irq, halt;
    logic [7:0]  dsp_data;
    logic        dsp_ready = 1'b0;

    assign bus = tb_drv ? tb_bus : {16{1'bz}};

    mem_ctrl #(.WAIT_STATES(WS), .ADDR_W(16)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .ld_mar(ld_mar), .ld_mdr(ld_mdr), .gate_mdr(gate_mdr),
        .mio_en(mio_en), .rw(rw), .rdy(rdy),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .kb_valid(kb_valid), .kb_data(kb_data), .kb_ready(kb_ready),
        .dsp_valid(dsp_valid), .dsp_data(dsp_data), .dsp_ready(dsp_ready),
        .kb_irq(kb_irq), .halt(halt)
    );

    always #5 clk = ~clk;

    // SRAM model with one-cycle read latency; counts write strobes
    logic [15:0] mem [0:65535];
    int          we_cnt = 0;
    logic [15:0] we_addr = '0, we_data = '0;
    always @(posedge clk) begin
        if (ram_en) ram_rdata <= mem[ram_addr];
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            we_cnt  <= we_cnt + 1;
            we_addr <= ram_addr;
            we_data <= ram_wdata;
        end
    end

    int n_checks = 0;
    int n_err    = 0;

    logic [15:0] sb_val[$];
    string       sb_name[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mar(input logic [15:0] v);
        tb_drv = 1'b1; tb_bus = v; ld_mar = 1'b1;
        tick();
        ld_mar = 1'b0; tb_drv = 1'b0;
    endtask

    task automatic set_mdr(input logic [15:0] v);
        tb_drv = 1'b1; tb_bus = v; ld_mdr = 1'b1;
        tick();
        ld_mdr = 1'b0; tb_drv = 1'b0;
    endtask

    task automatic read_mdr(output logic [15:0] v);
        gate_mdr = 1'b1;
        #1;
        v = bus;
        gate_mdr = 1'b0;
        #1;
    endtask

    // Full cpu-style access; returns MDR contents afterwards and rdy latency
    task automatic do_access(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                             output logic [15:0] rd, output int lat);
        set_mar(addr);
        if (wr) set_mdr(wdata);
        rw = wr; mio_en = 1'b1; ld_mdr = !wr; lat = 0;
        do begin
            tick();
            lat++;
        end while (!rdy && lat < 40);
        tick();
        mio_en = 1'b0; ld_mdr = 1'b0; rw = 1'b0;
        tick();
        read_mdr(rd);
    endtask

    // Scoreboard-checked access: expected value queued at issue, popped at completion
    task automatic sb_access(input string name, input logic wr, input logic [15:0] addr,
                             input logic [15:0] wdata, input logic [15:0] exp);
        logic [15:0] rd;
        logic [15:0] e;
        string       n;
        int          lat;
        sb_val.push_back(exp);
        sb_name.push_back(name);
        do_access(wr, addr, wdata, rd, lat);
        chk({name, "_lat"}, lat, WS + 2);
        e = sb_val.pop_front();
        n = sb_name.pop_front();
        chk(n, rd, e);
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
        logic        exp_halt;
        int          exp_we;
    } vec_t;

    vec_t vt[15];

    initial begin
        logic [15:0] v;
        int          w0;
        int          cnt_r;
        int          lat;

        vt[0]  = '{1'b0, 16'h3000, 16'h0000, 16'h1234, 1'b0, 0};
        vt[1]  = '{1'b1, 16'h4001, 16'hBEEF, 16'hBEEF, 1'b0, 1};
        vt[2]  = '{1'b0, 16'h4001, 16'h0000, 16'hBEEF, 1'b0, 0};
        vt[3]  = '{1'b0, 16'hFE08, 16'h0000, 16'h0000, 1'b0, 0};
        vt[4]  = '{1'b1, 16'hFFFE, 16'h0000, 16'h0000, 1'b1, 0};
        vt[5]  = '{1'b0, 16'hFFFE, 16'h0000, 16'h0000, 1'b1, 0};
        vt[6]  = '{1'b0, 16'hFE04, 16'h0000, 16'h8000, 1'b1, 0};
        vt[7]  = '{1'b1, 16'hFFFE, 16'h8000, 16'h8000, 1'b0, 0};
        vt[8]  = '{1'b0, 16'hFFFE, 16'h0000, 16'h8000, 1'b0, 0};
        vt[9]  = '{1'b1, 16'h0005, 16'h5A5A, 16'h5A5A, 1'b0, 1};
        vt[10] = '{1'b0, 16'h0005, 16'h0000, 16'h5A5A, 1'b0, 0};
        vt[11] = '{1'b1, 16'hFE08, 16'h1111, 16'h1111, 1'b0, 0};
        vt[12] = '{1'b0, 16'hFE08, 16'h0000, 16'h0000, 1'b0, 0};
        vt[13] = '{1'b1, 16'hFDFF, 16'h0F0F, 16'h0F0F, 1'b0, 1};
        vt[14] = '{1'b0, 16'hFDFF, 16'h0000, 16'h0F0F, 1'b0, 0};

        for (int unsigned i = 0; i < 65536; i++) mem[i] = '0;
        mem[16'h3000] = 16'h1234;

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_rdy", rdy, 1'b0);
        chk("rst_ram_en", ram_en, 1'b0);
        chk("rst_ram_we", ram_we, 1'b0);
        chk("rst_ram_addr", ram_addr, 16'h0000);
        chk("rst_kb_ready", kb_ready, 1'b1);
        chk("rst_kb_irq", kb_irq, 1'b0);
        chk("rst_dsp_valid", dsp_valid, 1'b0);
        chk("rst_halt", halt, 1'b0);
        read_mdr(v);
        chk("rst_mdr", v, 16'h0000);

        // Table-driven accesses
        for (int i = 0; i < 15; i++) begin
            w0 = we_cnt;
            sb_access($sformatf("vec%0d", i), vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].exp_rd);
            chk($sformatf("vec%0d_we", i), we_cnt - w0, vt[i].exp_we);
            if (vt[i].exp_we != 0) begin
                chk($sformatf("vec%0d_we_addr", i), we_addr, vt[i].addr);
                chk($sformatf("vec%0d_we_data", i), we_data, vt[i].wdata);
            end
            chk($sformatf("vec%0d_halt", i), halt, vt[i].exp_halt);
        end

        // Keyboard: accept, IE, read-clear, second char waits then lands
        kb_valid = 1'b1; kb_data = 8'h41;
        tick();
        kb_data = 8'h42;
        chk("kb_ready_busy", kb_ready, 1'b0);
        sb_access("kbsr_full", 1'b0, 16'hFE00, 16'h0, 16'h8000);
        sb_access("kbsr_wr", 1'b1, 16'hFE00, 16'h4000, 16'h4000);
        chk("kb_irq_on", kb_irq, 1'b1);
        sb_access("kbsr_ie", 1'b0, 16'hFE00, 16'h0, 16'hC000);
        sb_access("kbdr_1", 1'b0, 16'hFE02, 16'h0, 16'h0041);
        chk("kb_irq_char2", kb_irq, 1'b1);
        kb_valid = 1'b0;
        sb_access("kbdr_2", 1'b0, 16'hFE02, 16'h0, 16'h0042);
        chk("kb_irq_off", kb_irq, 1'b0);
        chk("kb_ready_free", kb_ready, 1'b1);
        sb_access("kbsr_empty", 1'b0, 16'hFE00, 16'h0, 16'h4000);

        // Display: write, overwrite while valid, handshake
        sb_access("ddr_wr", 1'b1, 16'hFE06, 16'h0048, 16'h0048);
        chk("dsp_valid_on", dsp_valid, 1'b1);
        chk("dsp_data_48", dsp_data, 8'h48);
        sb_access("dsr_busy", 1'b0, 16'hFE04, 16'h0, 16'h0000);
        sb_access("ddr_wr2", 1'b1, 16'hFE06, 16'h0049, 16'h0049);
        chk("dsp_data_49", dsp_data, 8'h49);
        chk("dsp_valid_still", dsp_valid, 1'b1);
        dsp_ready = 1'b1;
        tick();
        dsp_ready = 1'b0;
        chk("dsp_valid_off", dsp_valid, 1'b0);
        sb_access("dsr_ready", 1'b0, 16'hFE04, 16'h0, 16'h8000);

        // Dirty some state, then reset during the BUSY phase of a RAM write
        sb_access("mcr_halt", 1'b1, 16'hFFFE, 16'h0000, 16'h0000);
        sb_access("ddr_pre", 1'b1, 16'hFE06, 16'h0055, 16'h0055);
        kb_valid = 1'b1; kb_data = 8'h43;
        tick();
        kb_valid = 1'b0;
        chk("pre_rst_irq", kb_irq, 1'b1);
        set_mar(16'h5000);
        set_mdr(16'h7777);
        w0 = we_cnt;
        rw = 1'b1; mio_en = 1'b1;
        tick();
        tick();
        rst = 1'b1; mio_en = 1'b0; rw = 1'b0;
        tick();
        rst = 1'b0;
        cnt_r = 0;
        for (int i = 0; i < 6; i++) begin
            if (rdy) cnt_r++;
            tick();
        end
        chk("mid_rst_rdy", cnt_r, 0);
        chk("mid_rst_we", we_cnt - w0, 0);
        chk("mid_rst_mem", mem[16'h5000], 16'h0000);
        chk("mid_rst_addr", ram_addr, 16'h0000);
        chk("mid_rst_halt", halt, 1'b0);
        chk("mid_rst_dsp", dsp_valid, 1'b0);
        chk("mid_rst_kbrdy", kb_ready, 1'b1);
        chk("mid_rst_irq", kb_irq, 1'b0);
        read_mdr(v);
        chk("mid_rst_mdr", v, 16'h0000);
        sb_access("mid_rst_kbsr", 1'b0, 16'hFE00, 16'h0, 16'h0000);
        sb_access("mid_rst_dsr", 1'b0, 16'hFE04, 16'h0, 16'h8000);
        sb_access("mid_rst_mcr", 1'b0, 16'hFFFE, 16'h0, 16'h8000);

        // Held mio_en: one rdy only; ld_mdr with mio_en high and no rdy leaves MDR alone
        set_mar(16'h3000);
        rw = 1'b0; mio_en = 1'b1; ld_mdr = 1'b1; lat = 0;
        do begin
            tick();
            lat++;
        end while (!rdy && lat < 40);
        chk("held_lat", lat, WS + 2);
        tick();
        tb_drv = 1'b1; tb_bus = 16'h9999;
        cnt_r = 0;
        for (int i = 0; i < 10; i++) begin
            if (rdy) cnt_r++;
            tick();
        end
        chk("held_no_2nd_rdy", cnt_r, 0);
        mio_en = 1'b0; ld_mdr = 1'b0; tb_drv = 1'b0;
        tick();
        tick();
        chk("held_rdy_low", rdy, 1'b0);
        read_mdr(v);
        chk("held_mdr", v, 16'h1234);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "time limit");
    end

endmodule
